// File: rtl/handshake_coeff_sequencer_if.sv
// Handshake bundle between the coefficient sequencer and its control/consumer side.
// Latency: none, wires only.
// Backpressure: ctrl_valid/ctrl_ready for tokens, outs_valid/outs_ready for beats.
interface handshake_coeff_sequencer_if #(
  parameter int DATA_WIDTH = 24
);
  logic                  ctrl_valid;
  logic                  ctrl_ready;
  logic [DATA_WIDTH-1:0] outs;
  logic                  outs_valid;
  logic                  outs_ready;
  logic [1:0]            outs_idx;
  logic                  outs_last;
  logic                  busy;
  logic [7:0]            seq_count;

  // Sequencer side: consumes tokens and drives the coefficient stream.
  modport master (
    input  ctrl_valid,
    input  outs_ready,
    output ctrl_ready,
    output outs,
    output outs_valid,
    output outs_idx,
    output outs_last,
    output busy,
    output seq_count
  );

  // Peer side: offers tokens and sinks the coefficient stream.
  modport slave (
    output ctrl_valid,
    output outs_ready,
    input  ctrl_ready,
    input  outs,
    input  outs_valid,
    input  outs_idx,
    input  outs_last,
    input  busy,
    input  seq_count
  );
endinterface

// File: rtl/handshake_coeff_sequencer.sv
// Emits a fixed table of NUM_COEFFS coefficients for every accepted control token.
// Latency: first coefficient one cycle after token acceptance, then one per accepted beat.
// Backpressure: outputs hold while outs_ready=0; a new token is taken only when idle or on the last beat.
module handshake_coeff_sequencer #(
  parameter int                    DATA_WIDTH = 24,
  parameter int                    NUM_COEFFS = 4,
  parameter logic [DATA_WIDTH-1:0] COEFF0     = 24'h581679,
  parameter logic [DATA_WIDTH-1:0] COEFF1     = 24'h2AAAAB,
  parameter logic [DATA_WIDTH-1:0] COEFF2     = 24'h111111,
  parameter logic [DATA_WIDTH-1:0] COEFF3     = 24'h068068
) (
  input  logic                       clk,
  input  logic                       rst,
  handshake_coeff_sequencer_if.master bus
);

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

  localparam logic [1:0] LAST_IDX = 2'(NUM_COEFFS - 1);

  state_t                r_state;
  logic [DATA_WIDTH-1:0] r_outs;
  logic [1:0]            r_idx;
  logic                  r_valid;
  logic                  r_last;
  logic                  r_busy;
  logic [7:0]            r_seq_count;

  logic                  w_beat_hs;
  logic                  w_last_hs;
  logic                  w_ctrl_ready;
  logic                  w_tok;
  logic [1:0]            w_next_idx;

  function automatic logic [DATA_WIDTH-1:0] coeff_at(input logic [1:0] idx);
    case (idx)
      2'd0:    return COEFF0;
      2'd1:    return COEFF1;
      2'd2:    return COEFF2;
      default: return COEFF3;
    endcase
  endfunction

  // The only moment a busy sequencer can take a new token is the cycle its last beat leaves,
  // which is what allows back-to-back sequences without a bubble.
  assign w_beat_hs    = r_valid & bus.outs_ready;
  assign w_last_hs    = w_beat_hs & r_last;
  assign w_ctrl_ready = rst & ((r_state == IDLE) | w_last_hs);
  assign w_tok        = bus.ctrl_valid & w_ctrl_ready;
  assign w_next_idx   = r_idx + 2'd1;

  // Sequencer FSM with all stream outputs registered.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_outs      <= '0;
      r_idx       <= 2'd0;
      r_valid     <= 1'b0;
      r_last      <= 1'b0;
      r_busy      <= 1'b0;
      r_seq_count <= 8'd0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_tok) begin
            r_state <= EMIT;
            r_outs  <= COEFF0;
            r_idx   <= 2'd0;
            r_valid <= 1'b1;
            r_last  <= (LAST_IDX == 2'd0);
            r_busy  <= 1'b1;
          end
        end
        EMIT: begin
          if (w_beat_hs) begin
            if (r_last) begin
              r_seq_count <= r_seq_count + 8'd1;
              if (w_tok) begin
                // Chained token: restart the table straight away.
                r_outs  <= COEFF0;
                r_idx   <= 2'd0;
                r_last  <= (LAST_IDX == 2'd0);
              end else begin
                r_state <= IDLE;
                r_valid <= 1'b0;
                r_last  <= 1'b0;
                r_busy  <= 1'b0;
              end
            end else begin
              r_idx  <= w_next_idx;
              r_outs <= coeff_at(w_next_idx);
              r_last <= (w_next_idx == LAST_IDX);
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Table depth is fixed at four entries; anything outside 1..4 has no meaning.
  a_num_coeffs_legal: assert property (@(posedge clk) (NUM_COEFFS >= 1) && (NUM_COEFFS <= 4));

  assign bus.ctrl_ready = w_ctrl_ready;
  assign bus.outs       = r_outs;
  assign bus.outs_valid = r_valid;
  assign bus.outs_idx   = r_idx;
  assign bus.outs_last  = r_last;
  assign bus.busy       = r_busy;
  assign bus.seq_count  = r_seq_count;

endmodule

// File: tb/tb_handshake_coeff_sequencer.sv
// Bench for handshake_coeff_sequencer: a 4-coefficient and a 1-coefficient instance.
// Expected beats are queued on token acceptance and popped on beat handshakes.
// Inputs change 1ns after the rising edge; outputs are checked on the falling edge.
module tb_handshake_coeff_sequencer;

  typedef struct packed {
    logic [23:0] dat;
    logic [1:0]  idx;
    logic        last;
  } beat_t;

  localparam logic [23:0] COEF [4] = '{24'h581679, 24'h2AAAAB, 24'h111111, 24'h068068};

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  handshake_coeff_sequencer_if #(.DATA_WIDTH(24)) a_if ();
  handshake_coeff_sequencer_if #(.DATA_WIDTH(24)) b_if ();

  handshake_coeff_sequencer #(.DATA_WIDTH(24), .NUM_COEFFS(4)) u_dut_a (
    .clk (clk),
    .rst (rst),
    .bus (a_if)
  );

  handshake_coeff_sequencer #(.DATA_WIDTH(24), .NUM_COEFFS(1)) u_dut_b (
    .clk (clk),
    .rst (rst),
    .bus (b_if)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Scoreboard for the 4-coefficient instance.
  beat_t      qa[$];
  logic [7:0] a_seq   = 8'd0;
  logic       a_rflag = 1'b1;

  initial begin
    logic  exp_rdy;
    logic  hs;
    logic  last_hs;
    logic  acc;
    beat_t b;
    forever begin
      @(negedge clk);
      chk("a_valid", 32'(a_if.outs_valid), 32'(qa.size() != 0));
      chk("a_busy", 32'(a_if.busy), 32'(qa.size() != 0));
      chk("a_seq_count", 32'(a_if.seq_count), 32'(a_seq));
      if (qa.size() != 0) begin
        chk("a_outs", 32'(a_if.outs), 32'(qa[0].dat));
        chk("a_idx", 32'(a_if.outs_idx), 32'(qa[0].idx));
        chk("a_last", 32'(a_if.outs_last), 32'(qa[0].last));
      end else begin
        chk("a_last_idle", 32'(a_if.outs_last), 32'(0));
      end
      if (a_rflag) begin
        chk("a_outs_rst", 32'(a_if.outs), 32'(0));
        chk("a_idx_rst", 32'(a_if.outs_idx), 32'(0));
      end
      exp_rdy = rst && ((qa.size() == 0) || (qa[0].last && a_if.outs_ready));
      chk("a_ctrl_ready", 32'(a_if.ctrl_ready), 32'(exp_rdy));
      // Advance the model to the state after the coming rising edge.
      if (!rst) begin
        qa.delete();
        a_seq   = 8'd0;
        a_rflag = 1'b1;
      end else begin
        hs      = (qa.size() != 0) && a_if.outs_ready;
        last_hs = hs && qa[0].last;
        acc     = a_if.ctrl_valid && ((qa.size() == 0) || last_hs);
        if (hs) begin
          if (last_hs) a_seq = a_seq + 8'd1;
          void'(qa.pop_front());
        end
        if (acc) begin
          a_rflag = 1'b0;
          for (int i = 0; i < 4; i++) begin
            b.dat  = COEF[i];
            b.idx  = 2'(i);
            b.last = (i == 3);
            qa.push_back(b);
          end
        end
      end
    end
  end

  // Scoreboard for the single-coefficient instance.
  beat_t      qb[$];
  logic [7:0] b_seq   = 8'd0;
  logic       b_rflag = 1'b1;

  initial begin
    logic  exp_rdy;
    logic  hs;
    logic  acc;
    beat_t b;
    forever begin
      @(negedge clk);
      chk("b_valid", 32'(b_if.outs_valid), 32'(qb.size() != 0));
      chk("b_busy", 32'(b_if.busy), 32'(qb.size() != 0));
      chk("b_seq_count", 32'(b_if.seq_count), 32'(b_seq));
      if (qb.size() != 0) begin
        chk("b_outs", 32'(b_if.outs), 32'(qb[0].dat));
        chk("b_idx", 32'(b_if.outs_idx), 32'(qb[0].idx));
        chk("b_last", 32'(b_if.outs_last), 32'(qb[0].last));
      end else begin
        chk("b_last_idle", 32'(b_if.outs_last), 32'(0));
      end
      if (b_rflag) begin
        chk("b_outs_rst", 32'(b_if.outs), 32'(0));
      end
      exp_rdy = rst && ((qb.size() == 0) || b_if.outs_ready);
      chk("b_ctrl_ready", 32'(b_if.ctrl_ready), 32'(exp_rdy));
      if (!rst) begin
        qb.delete();
        b_seq   = 8'd0;
        b_rflag = 1'b1;
      end else begin
        hs  = (qb.size() != 0) && b_if.outs_ready;
        acc = b_if.ctrl_valid && ((qb.size() == 0) || hs);
        if (hs) begin
          b_seq = b_seq + 8'd1;
          void'(qb.pop_front());
        end
        if (acc) begin
          b_rflag = 1'b0;
          b.dat   = COEF[0];
          b.idx   = 2'd0;
          b.last  = 1'b1;
          qb.push_back(b);
        end
      end
    end
  end

  // Directed stimulus, then a random stall phase.
  initial begin
    a_if.ctrl_valid = 1'b0;
    a_if.outs_ready = 1'b0;
    b_if.ctrl_valid = 1'b0;
    b_if.outs_ready = 1'b0;
    rst             = 1'b0;
    tick(2);
    rst = 1'b1;
    tick(1);

    // Single token, consumer always ready.
    a_if.ctrl_valid = 1'b1;
    a_if.outs_ready = 1'b1;
    tick(1);
    a_if.ctrl_valid = 1'b0;
    tick(6);
    chk("a_seq_after_first", 32'(a_if.seq_count), 32'(1));

    // Stall five cycles while index 1 is on the output.
    a_if.ctrl_valid = 1'b1;
    a_if.outs_ready = 1'b0;
    tick(1);
    a_if.ctrl_valid = 1'b0;
    a_if.outs_ready = 1'b1;
    tick(1);
    a_if.outs_ready = 1'b0;
    tick(5);
    chk("a_hold_dat", 32'(a_if.outs), 32'(24'h2AAAAB));
    chk("a_hold_idx", 32'(a_if.outs_idx), 32'(1));
    a_if.outs_ready = 1'b1;
    tick(4);
    chk("a_seq_after_stall", 32'(a_if.seq_count), 32'(2));

    // Token held high: two sequences back to back.
    a_if.ctrl_valid = 1'b1;
    tick(5);
    a_if.ctrl_valid = 1'b0;
    tick(6);
    chk("a_seq_after_b2b", 32'(a_if.seq_count), 32'(4));

    // Reset while index 2 is on the output.
    a_if.ctrl_valid = 1'b1;
    tick(1);
    a_if.ctrl_valid = 1'b0;
    tick(2);
    chk("a_idx_before_rst", 32'(a_if.outs_idx), 32'(2));
    rst = 1'b0;
    tick(1);
    chk("a_valid_rst", 32'(a_if.outs_valid), 32'(0));
    chk("a_seq_rst", 32'(a_if.seq_count), 32'(0));
    rst = 1'b1;
    tick(2);
    a_if.ctrl_valid = 1'b1;
    tick(1);
    a_if.ctrl_valid = 1'b0;
    chk("a_restart_idx", 32'(a_if.outs_idx), 32'(0));
    tick(5);

    // Single-coefficient instance: 256 chained one-beat sequences wrap the counter.
    b_if.outs_ready = 1'b1;
    b_if.ctrl_valid = 1'b1;
    tick(128);
    chk("b_seq_mid", 32'(b_if.seq_count), 32'(127));
    tick(128);
    b_if.ctrl_valid = 1'b0;
    tick(2);
    chk("b_seq_wrap", 32'(b_if.seq_count), 32'(0));

    // Random token offers and consumer stalls on both instances.
    for (int i = 0; i < 400; i++) begin
      a_if.ctrl_valid = 1'($urandom_range(0, 3) == 0);
      a_if.outs_ready = 1'($urandom_range(0, 9) < 6);
      b_if.ctrl_valid = 1'($urandom_range(0, 1));
      b_if.outs_ready = 1'($urandom_range(0, 9) < 6);
      tick(1);
    end
    a_if.ctrl_valid = 1'b0;
    b_if.ctrl_valid = 1'b0;
    a_if.outs_ready = 1'b1;
    b_if.outs_ready = 1'b1;
    tick(8);
    chk("a_drained", 32'(a_if.outs_valid), 32'(0));
    chk("b_drained", 32'(b_if.outs_valid), 32'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
